// File: rtl/pack_n.sv
// pack_n: serial-to-parallel packer of N DW-bit words; optional partial-group flush via PACK_N_FLUSH_EN
module pack_n #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*DW-1:0] out_data,
  output logic            out_valid,
`ifdef PACK_N_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            out_ready
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  logic [IW-1:0]       idx;
  logic [(N-1)*DW-1:0] fill;
  logic [N*DW-1:0]     grp;
  logic                can_load, acc, last, flush_go, load;
  assign can_load = !out_valid || out_ready;
  assign last     = idx == LAST;
  assign in_ready = !last || can_load;
  assign acc      = in_valid && in_ready;
`ifdef PACK_N_FLUSH_EN
  assign flush_go = flush && can_load && (idx != '0 || acc);
`else
  assign flush_go = 1'b0;
`endif
  assign load = (acc && last) || flush_go;
  for (genvar g = 0; g < N; g++) begin : g_grp
    localparam logic [IW-1:0] K = IW'(g);
    if (g < N - 1) begin : g_fill
      assign grp[g*DW +: DW] = (K < idx) ? fill[g*DW +: DW] : (acc && K == idx) ? in_data : '0;
    end else begin : g_top
      assign grp[g*DW +: DW] = (acc && K == idx) ? in_data : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      fill      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= grp;
      out_valid <= 1'b1;
      idx       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (acc) begin
        fill[idx*DW +: DW] <= in_data;
        idx                <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pack_n.sv
// tb_pack_n: directed self-checking bench for pack_n (N=4, DW=8)
module tb_pack_n;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  int          passed = 0, total = 0;

  always #5 clk = ~clk;

  pack_n #(.N(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
`ifdef PACK_N_FLUSH_EN
    .flush(flush),
`endif
    .out_ready(out_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'hFF; out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 00000000", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (dut.idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", dut.idx); else passed++;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      total++;
      if (out_valid !== (i == 4)) $display("FAIL basic_valid word %0d got %b want %b", i, out_valid, i == 4);
      else passed++;
    end
    total++; if (out_data !== 32'h04030201) $display("FAIL basic_data got %h want 04030201", out_data); else passed++;
    in_valid = 1'b0; in_data = 8'h55;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_stream;
    logic [31:0] exp;
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready word %0d got %b want 1", k, in_ready); else passed++;
      tick();
      total++;
      if (out_valid !== (k % 4 == 0)) $display("FAIL stream_valid word %0d got %b want %b", k, out_valid, k % 4 == 0);
      else passed++;
      if (k % 4 == 0) begin
        exp = {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
        total++; if (out_data !== exp) $display("FAIL stream_data word %0d got %h want %h", k, out_data, exp); else passed++;
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready word %0d got %b want 1", k, in_ready); else passed++;
      tick();
    end
    in_data = 8'h08;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_stall got %b want 0", in_ready); else passed++;
    total++; if (dut.idx !== 2'd3) $display("FAIL bp_idx got %0d want 3", dut.idx); else passed++;
    total++; if (out_data !== 32'h04030201) $display("FAIL bp_hold got %h want 04030201", out_data); else passed++;
    tick();
    total++; if (out_data !== 32'h04030201) $display("FAIL bp_hold2 got %h want 04030201", out_data); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid got %b want 1", out_valid); else passed++;
    total++; if (dut.idx !== 2'd3) $display("FAIL bp_idx2 got %0d want 3", dut.idx); else passed++;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else passed++;
    tick();
    total++; if (out_data !== 32'h08070605) $display("FAIL bp_second got %h want 08070605", out_data); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_second_valid got %b want 1", out_valid); else passed++;
    total++; if (dut.idx !== 2'd0) $display("FAIL bp_idx_wrap got %0d want 0", dut.idx); else passed++;
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL rmid_data got %h want 00000000", out_data); else passed++;
    total++; if (dut.idx !== 2'd0) $display("FAIL rmid_idx got %0d want 0", dut.idx); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", in_ready); else passed++;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      total++;
      if (out_valid !== (i == 4)) $display("FAIL rmid_group_valid word %0d got %b want %b", i, out_valid, i == 4);
      else passed++;
    end
    total++; if (out_data !== 32'h04030201) $display("FAIL rmid_group got %h want 04030201", out_data); else passed++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_idle_gaps;
    logic [7:0] seq_d [8] = '{8'hA1, 8'h5A, 8'hA2, 8'hC3, 8'h99, 8'hA3, 8'h77, 8'hA4};
    logic       seq_v [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = seq_v[i];
      in_data  = seq_v[i] ? seq_d[i] : 8'($urandom);
      tick();
      total++;
      if (out_valid !== (i == 7)) $display("FAIL idle_valid step %0d got %b want %b", i, out_valid, i == 7);
      else passed++;
    end
    total++; if (out_data !== 32'hA4A3A2A1) $display("FAIL idle_data got %h want a4a3a2a1", out_data); else passed++;
    in_valid = 1'b0;
    tick();
  endtask

`ifdef PACK_N_FLUSH_EN
  task automatic test_flush;
    out_ready = 1'b1;
    in_valid = 1'b0; flush = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_idle got %b want 0", out_valid); else passed++;
    flush = 1'b0;
    in_valid = 1'b1; in_data = 8'h05; tick();
    in_data = 8'h06; tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (out_data !== 32'h00000605) $display("FAIL flush_data got %h want 00000605", out_data); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL flush_valid got %b want 1", out_valid); else passed++;
    total++; if (dut.idx !== 2'd0) $display("FAIL flush_idx got %0d want 0", dut.idx); else passed++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_idle_gaps();
`ifdef PACK_N_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pack_n.md
# pack_N

Serial-to-parallel packer that sits directly upstream of `add_N`. It accepts a stream of DW-bit words over a valid/ready handshake and assembles every N consecutive words into one packed N×DW vector. The packed vector drives `add_N`'s `inp` bus, or any other consumer of a packed vector. Groups are presented on a valid/ready output and held until taken, so the producer is back-pressured rather than dropping data.

## Interface
- `N`, default 4: words per packed group; N ≥ 2.
- `DW`, default 8: word width in bits.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_data` input, DW bits: incoming word.
- `in_valid` input, 1 bit: `in_data` is valid this cycle.
- `in_ready` output, 1 bit: block accepts a word this cycle.
- `out_data` output, N*DW bits: packed group; element k at bits [k*DW +: DW].
- `out_valid` output, 1 bit: `out_data` holds a complete group.
- `out_ready` input, 1 bit: consumer takes `out_data` this cycle.
- `flush` input, 1 bit: present only when `PACK_N_FLUSH_EN` is defined.

## Operation
- Input transfer occurs when `in_valid && in_ready` at a rising edge. Output transfer occurs when `out_valid && out_ready`.
- Storage:
  - Fill register: N-1 words.
  - Fill index `idx`, range 0..N-1, width $clog2(N).
  - Output register: N*DW bits, plus the `out_valid` flag.
- Element order: the first word accepted in a group lands in bits [DW-1:0]; the k-th lands in [k*DW +: DW].
- Accept with `idx < N-1`: write the word to fill slot `idx`, then `idx <= idx+1`.
- Accept with `idx == N-1`: load the output register with {in_data, fill[N-2..0]}, set `out_valid`, and set `idx <= 0`.
- Output register can accept a new group when `!out_valid || out_ready`. The drain and the load may happen in the same cycle, so back-to-back groups need no bubble.
- `in_ready` = (`idx != N-1`) || !`out_valid` || `out_ready`. This is combinational from `out_ready`, which is permitted.
- Output transfer without a simultaneous load: `out_valid <= 0`.
- `out_data` stays stable while `out_valid && !out_ready`.
- `in_data` is ignored when no input transfer occurs.
- Unused fill slots hold stale values. They are never exposed, except as zeros under flush.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `idx` = 0, fill register = 0.
- `in_ready` is 1 out of reset.
- Reset has priority over every other input in the same cycle. A reset mid-group discards the partial group and any held output.
- Latency: `out_valid` rises on the edge that accepts the N-th word, so it is visible one cycle after that word is presented.
- Throughput: one word per cycle sustained. With `out_ready` held at 1, one group every N cycles.
- Stall: `in_ready` is 0 only when `idx == N-1`, `out_valid` = 1 and `out_ready` = 0.
- `idx` wraps from N-1 to 0 without gaps; groups never straddle.

## Configuration
- `PACK_N_FLUSH_EN` defined:
  - Adds the `flush` input.
  - When `flush` = 1, `idx != 0`, and the output register can accept, a partial group is moved to the output register with unfilled elements zeroed. `out_valid` is set and `idx <= 0`.
  - An input word accepted in the same cycle is included in that flushed group. If that word completes the group, it is a normal full group.
  - `flush` with `idx == 0` and no input transfer does nothing.
  - `flush` while the output register is blocked is held off (no effect) until the register can accept. The upstream keeps `flush` asserted.
- `PACK_N_FLUSH_EN` not defined: no `flush` port; only complete N-word groups are ever emitted.

## Test plan
- Basic packing (N=4, DW=8), `out_ready` = 1: send 0x01, 0x02, 0x03, 0x04 on consecutive cycles. Required: `out_data` = 0x04030201 with `out_valid` = 1 for exactly one cycle, one cycle after 0x04.
- Streaming: send 0x01..0x0C continuously with `out_ready` = 1. Required: groups 0x04030201, 0x08070605, 0x0C0B0A09; `in_ready` never drops.
- Backpressure: `out_ready` = 0, offer 0x01..0x08.
  - `in_ready` must drop after 0x07 is accepted, with `idx` = 3 and `out_data` holding 0x04030201.
  - Raise `out_ready`. Required: 0x04030201 transfers, 0x08 is accepted the same cycle, and 0x08070605 follows.
- Reset mid-group: send 0x11, 0x22, assert `rst` for one cycle, then send 0x01..0x04. Required: only 0x04030201 is emitted; all outputs are 0 on the cycle after reset.
- Idle gaps: interleave `in_valid` = 0 cycles with random `in_data` between 0xA1..0xA4. Required: 0xA4A3A2A1 is emitted and the gap data is ignored.
- Flush (`PACK_N_FLUSH_EN` defined): send 0x05, 0x06, then `flush` = 1. Required: `out_data` = 0x00000605, `out_valid` = 1, `idx` returns to 0.
